vga_framebuffer_writer: RTL and testbench
=========================================

// Module: vga_framebuffer_writer
// PURPOSE
//  Write side of the 320x240, 2-bit-per-pixel VGA framebuffer. Accepts a raster
//  pixel stream (valid/ready, start-of-frame and end-of-line markers) and
//  generates linear write addresses, y*FB_WIDTH + x. Writes go through a small
//  FIFO to a granted memory write port. The VGA scan-out reads the same memory
//  from address 0 upward, one pixel per address.
// PARAMETERS
//  FB_WIDTH    320  pixels per line; eol is expected on pixel FB_WIDTH-1
//  FB_HEIGHT   240  lines per frame
//  FIFO_DEPTH  4    write-queue entries, power of 2, >= 2
//  ADDR_W      17   framebuffer address width
// PORTS
//  vga_clk_25  in   1       pixel clock; all logic on rising edge
//  reset_n     in   1       synchronous, active-low reset
//  s_valid     in   1       input pixel beat valid
//  s_ready     out  1       input can accept a beat
//  s_data      in   2       RAW pixel value
//  s_sof       in   1       beat is pixel (0,0) of a frame
//  s_eol       in   1       beat is the last pixel of a line
//  fb_we       out  1       write request to framebuffer
//  fb_addr     out  ADDR_W  write address
//  fb_din      out  2       write data
//  fb_gnt      in   1       memory accepts the write this cycle
//  frame_done  out  1       1-cycle pulse: full frame accepted on the input side
//  line_err    out  1       1-cycle pulse: framing error detected
//  busy        out  1       state ACTIVE or FIFO non-empty
// BEHAVIOUR
//  Reset (reset_n low at a clock edge): state WAIT_SOF, x=y=0, address counter 0,
//   FIFO emptied and pending writes discarded. fb_we, frame_done, line_err and
//   busy are 0. s_ready is 0 while reset_n is low.
//  Beat accepted = s_valid & s_ready. s_ready = !fifo_full in every state.
//  FSM, input side:
//   WAIT_SOF: accepted beats with s_sof=0 are discarded. An s_sof beat is pushed
//    at addr 0, then x=1, y=0 and the state goes to ACTIVE.
//   ACTIVE: every accepted beat is pushed at the address counter, then the
//    counter and x increment.
//    - s_eol with x==FB_WIDTH-1: x=0, y++. If y was FB_HEIGHT-1, pulse frame_done
//      and go to WAIT_SOF.
//    - s_eol with x<FB_WIDTH-1 (short line), or x==FB_WIDTH-1 without s_eol
//      (long line): the pixel is written, line_err pulses and the state goes to DROP.
//    - s_sof: line_err pulses; the beat is treated as a new frame start (push at
//      addr 0, x=1, y=0) and the state stays ACTIVE.
//   DROP: non-sof beats are discarded. An s_sof beat is handled as in WAIT_SOF.
//   An s_sof beat that also carries s_eol (FB_WIDTH>1) is a short line: the
//    pixel is written, line_err pulses and the state goes to DROP.
//  Write side: the FIFO holds {addr,data} entries. fb_we = !fifo_empty, and
//   fb_addr/fb_din show the FIFO head. The head is popped when fb_we & fb_gnt.
//   fb_addr/fb_din stay stable while fb_we=1 and fb_gnt=0.
//  Latency: a beat accepted into an empty FIFO appears on fb_we on the next cycle.
//   With fb_gnt held high, throughput is 1 write per cycle.
//  Push and pop in the same cycle: occupancy is unchanged; this is legal when full.
//  frame_done and line_err are registered and assert the cycle after the
//   triggering beat. frame_done does not wait for the FIFO to drain; use busy
//   for that.
//  Address arithmetic: the counter spans 0..FB_WIDTH*FB_HEIGHT-1 (76799) and does
//   not wrap within a frame. It is reset to 0 only by an s_sof beat.
// TESTING
//  1. Reset, then a full 320x240 frame with fb_gnt=1 -> 76800 writes at addr
//     0..76799 in order. frame_done pulses once, the cycle after eol on line 239.
//  2. fb_gnt=0 for 10 cycles mid-line -> s_ready falls after 4 accepted beats.
//     fb_addr/fb_din are held. On grant the writes resume with no loss or
//     duplicates.
//  3. eol on x=100 of line 5 -> pixel written at addr 1700, line_err pulses, later
//     beats are dropped until sof. Next sof writes addr 0.
//  4. Line with no eol at x=319 -> line_err pulses and the state goes to DROP.
//     Beats before sof (including pixel 320) produce no writes.
//  5. sof at line 10, x=50 -> line_err pulses and the next write is at addr 0.
//     The full frame then completes with frame_done.
//  6. reset_n low for 1 cycle with 3 entries queued -> fb_we=0 on the next cycle.
//     The state is WAIT_SOF and non-sof beats are ignored.

Source files
------------

// File: rtl/vga_framebuffer_writer.sv
// Write side of the VGA framebuffer: turns a raster pixel stream into linear
// y*FB_WIDTH+x writes, queued through a small FIFO to a granted memory port.
module vga_framebuffer_writer #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 17
) (
  input  logic              vga_clk_25,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [1:0]        s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [1:0]        fb_din,
  input  logic              fb_gnt,
  output logic              frame_done,
  output logic              line_err,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int X_W   = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int Y_W   = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(FB_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FB_HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_WAIT_SOF,
    ST_ACTIVE,
    ST_DROP
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        data;
  } entry_t;

  state_e            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_done_q, frame_done_d;
  logic              line_err_q, line_err_d;

  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  entry_t            mem_q [FIFO_DEPTH];
  logic              fifo_full, fifo_empty;
  logic              accept, push, pop;
  logic [ADDR_W-1:0] push_addr;
  entry_t            head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign s_ready = reset_n & ~fifo_full;
  assign accept  = s_valid & s_ready;
  assign fb_we   = ~fifo_empty;
  assign pop     = fb_we & fb_gnt;
  assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign fb_addr = head.addr;
  assign fb_din  = head.data;

  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign busy       = (state_q == ST_ACTIVE) | ~fifo_empty;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    push         = 1'b0;
    push_addr    = addr_q;
    frame_done_d = 1'b0;
    line_err_d   = 1'b0;

    if (accept) begin
      if (s_sof) begin
        // A start-of-frame restarts the raster from any state.
        push      = 1'b1;
        push_addr = '0;
        addr_d    = ADDR_W'(1);
        x_d       = X_W'(1);
        y_d       = '0;
        state_d   = ST_ACTIVE;
        if (state_q == ST_ACTIVE) line_err_d = 1'b1;
        if (s_eol && FB_WIDTH > 1) begin
          line_err_d = 1'b1;
          state_d    = ST_DROP;
        end
      end else if (state_q == ST_ACTIVE) begin
        push   = 1'b1;
        addr_d = addr_q + 1'b1;
        x_d    = x_q + 1'b1;
        if (x_q == X_LAST) begin
          if (s_eol) begin
            x_d = '0;
            y_d = y_q + 1'b1;
            if (y_q == Y_LAST) begin
              frame_done_d = 1'b1;
              state_d      = ST_WAIT_SOF;
            end
          end else begin
            line_err_d = 1'b1;
            state_d    = ST_DROP;
          end
        end else if (s_eol) begin
          line_err_d = 1'b1;
          state_d    = ST_DROP;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT_SOF;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; emptying the pointers is enough to discard it.
  always_ff @(posedge vga_clk_25) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= '{addr: push_addr, data: s_data};
  end

endmodule

// File: tb/tb_vga_framebuffer_writer.sv
// Randomized bench for vga_framebuffer_writer: a raster-rule model predicts the
// write queue, flags and handshake every cycle; literal checks pin the scenarios.
`timescale 1ns/1ps
module tb_vga_framebuffer_writer;

  localparam int W     = 320;
  localparam int H     = 24;
  localparam int DEPTH = 4;
  localparam int AW    = 17;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [1:0]    s_data = '0;
  logic          s_sof = 1'b0;
  logic          s_eol = 1'b0;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [1:0]    fb_din;
  logic          fb_gnt = 1'b0;
  logic          frame_done;
  logic          line_err;
  logic          busy;

  vga_framebuffer_writer #(
    .FB_WIDTH(W), .FB_HEIGHT(H), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .vga_clk_25(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .s_eol(s_eol),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din), .fb_gnt(fb_gnt),
    .frame_done(frame_done), .line_err(line_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected pending writes plus raster position.
  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    data;
  } wr_t;

  wr_t exp_q[$];
  bit  m_in_frame = 0;
  int  m_x = 0;
  int  m_y = 0;
  bit  m_fd = 0;
  bit  m_le = 0;
  int  m_occ;
  bit  chk_en = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_in_frame = 0; m_x = 0; m_y = 0; m_fd = 0; m_le = 0;
    end else begin
      m_occ = exp_q.size();
      m_fd = 0;
      m_le = 0;
      if (m_occ > 0 && fb_gnt) void'(exp_q.pop_front());
      if (s_valid && m_occ < DEPTH) begin
        if (s_sof) begin
          m_le = m_in_frame;
          exp_q.push_back('{addr: '0, data: s_data});
          m_x = 1; m_y = 0; m_in_frame = 1;
          if (s_eol) begin m_le = 1; m_in_frame = 0; end
        end else if (m_in_frame) begin
          exp_q.push_back('{addr: AW'(m_y * W + m_x), data: s_data});
          if (m_x == W - 1 && s_eol) begin
            m_x = 0;
            m_y++;
            if (m_y == H) begin m_fd = 1; m_in_frame = 0; end
          end else if (m_x == W - 1 || s_eol) begin
            m_le = 1; m_in_frame = 0;
          end else begin
            m_x++;
          end
        end
      end
    end
  end

  // Observed-write bookkeeping for the literal scenario checks.
  int wr_cnt = 0;
  int fd_cnt = 0;
  int le_cnt = 0;
  logic [AW-1:0] last_addr = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready", s_ready, reset_n && exp_q.size() < DEPTH);
      check("fb_we", fb_we, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("fb_addr", fb_addr, exp_q[0].addr);
        check("fb_din", fb_din, exp_q[0].data);
      end
      check("frame_done", frame_done, m_fd);
      check("line_err", line_err, m_le);
      check("busy", busy, m_in_frame || exp_q.size() != 0);
      if (fb_we && fb_gnt) begin wr_cnt++; last_addr = fb_addr; end
      if (frame_done) fd_cnt++;
      if (line_err) le_cnt++;
    end
  end

  int gnt_pct = 100;
  bit gnt_hold = 0;
  int idle_pct = 0;

  always @(posedge clk) begin
    #1;
    fb_gnt = !gnt_hold && ($urandom_range(99) < gnt_pct);
  end

  task automatic beat(input bit sof, input bit eol);
    bit acc;
    int n;
    if (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_sof = sof; s_eol = eol; s_data = 2'($urandom);
    acc = 0;
    n = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("beat_accept", acc, 1);
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic line(input int len, input bit eol_last, input bit sof_first);
    for (int i = 0; i < len; i++) beat(sof_first && i == 0, eol_last && i == len - 1);
  endtask

  task automatic frame();
    for (int y = 0; y < H; y++) line(W, 1, y == 0);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fb_we && n < 2000);
    check("drain", fb_we, 0);
    @(posedge clk); #1;
  endtask

  int w0, f0, l0;

  initial begin
    #1_000_000;
    check("watchdog", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset values.
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_line_err", line_err, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Full frame with grant high, plus a 10-cycle grant stall mid-line.
    w0 = wr_cnt; f0 = fd_cnt; l0 = le_cnt;
    fork
      frame();
      begin
        repeat (1000) @(posedge clk);
        #1;
        gnt_hold = 1;
        repeat (10) @(negedge clk);
        check("stall_s_ready", s_ready, 0);
        check("stall_fb_we", fb_we, 1);
        gnt_hold = 0;
      end
    join
    drain();
    check("t1_writes", wr_cnt - w0, W * H);
    check("t1_last_addr", last_addr, W * H - 1);
    check("t1_frame_done", fd_cnt - f0, 1);
    check("t1_line_err", le_cnt - l0, 0);

    // Short line: eol on x=100 of line 5.
    idle_pct = 20;
    w0 = wr_cnt; l0 = le_cnt;
    for (int y = 0; y < 5; y++) line(W, 1, y == 0);
    line(101, 1, 0);
    line(40, 0, 0);
    drain();
    check("t3_writes", wr_cnt - w0, 5 * W + 101);
    check("t3_last_addr", last_addr, 1700);
    check("t3_line_err", le_cnt - l0, 1);
    beat(1, 0);
    drain();
    check("t3_sof_addr", last_addr, 0);

    // Long line: no eol at x=319 of line 1.
    w0 = wr_cnt; l0 = le_cnt;
    line(W - 1, 1, 0);
    line(W, 0, 0);
    line(5, 0, 0);
    drain();
    check("t4_writes", wr_cnt - w0, 2 * W - 1);
    check("t4_last_addr", last_addr, 2 * W - 1);
    check("t4_line_err", le_cnt - l0, 1);

    // sof at line 10, x=50, then a complete frame with random grant.
    gnt_pct = 60;
    l0 = le_cnt;
    for (int y = 0; y < 10; y++) line(W, 1, y == 0);
    line(50, 0, 0);
    beat(1, 0);
    drain();
    check("t5_sof_addr", last_addr, 0);
    check("t5_line_err", le_cnt - l0, 1);
    f0 = fd_cnt;
    line(W - 1, 1, 0);
    for (int y = 1; y < H; y++) line(W, 1, 0);
    drain();
    check("t5_frame_done", fd_cnt - f0, 1);
    check("t5_last_addr", last_addr, W * H - 1);

    // Reset with three writes queued.
    idle_pct = 0;
    gnt_hold = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    beat(1, 0); beat(0, 0); beat(0, 0);
    check("t6_queued_we", fb_we, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    gnt_hold = 0;
    @(negedge clk);
    check("t6_fb_we", fb_we, 0);
    check("t6_busy", busy, 0);
    @(posedge clk); #1;
    w0 = wr_cnt;
    line(20, 0, 0);
    drain();
    check("t6_no_writes", wr_cnt - w0, 0);

    // Random mix of good and malformed lines.
    gnt_pct = 70;
    idle_pct = 25;
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(9))
        0: line(W, 1, 1);
        1: line($urandom_range(W - 2, 1), 1, 0);
        2: line(W + $urandom_range(3, 0), 0, 0);
        3: beat(1, 1);
        4: begin line($urandom_range(W - 1, 1), 0, 0); beat(1, 0); end
        default: line(W, 1, 0);
      endcase
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
